// File: rtl/flt_stream_pkg.sv
// Shared helpers for the clock-enable stream controller: counter/pointer
// widths and the LATENCY/BUF_DEPTH legality rule.
package flt_stream_pkg;

    // Bits needed to count from 0 up to and including n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Bits needed to address n entries (at least one bit).
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The buffer must hold every in-flight token plus one, or the stream
    // could deadlock with a full pipeline and no room to land its output.
    function automatic bit cfg_legal(input int latency, input int buf_depth);
        return (latency >= 1) && (buf_depth >= latency + 1);
    endfunction

endpackage

// File: rtl/flt_stream_fifo.sv
// First-word-fall-through skid FIFO: synchronous write, asynchronous read,
// pointers wrap at DEPTH-1 so any depth is legal.
module flt_stream_fifo
    import flt_stream_pkg::*;
#(
    parameter int DEPTH = 18,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Capture the incoming word at the write pointer.
    // NOTE: storage has no reset; only the pointers and count define which
    // entries are live, so clearing the array would just cost reset fan-out.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Advance pointers and track fill level; push and pop together leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_valid = (fifo_cnt != '0);
    assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/flt_aclken_stream_ctrl.sv
// Valid/ready adapter around a fixed-latency clock-enabled pipeline. Drives
// the pipeline enable, tracks in-flight tokens with a valid chain, and lands
// the pipeline output in a skid FIFO sized by a credit count.
module flt_aclken_stream_ctrl
    import flt_stream_pkg::*;
#(
    parameter int LATENCY    = 16,
    parameter int DATA_WIDTH = 16,
    parameter int BUF_DEPTH  = 18
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              s_valid,
    output logic                              s_ready,
    output logic                              aclken,
    input  logic [DATA_WIDTH-1:0]             pipe_dout,
    output logic                              m_valid,
    output logic [DATA_WIDTH-1:0]             m_data,
    input  logic                              m_ready,
    output logic [cnt_width(BUF_DEPTH)-1:0]   occupancy
);

    localparam int OCC_W = cnt_width(BUF_DEPTH);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(BUF_DEPTH);

    if (!cfg_legal(LATENCY, BUF_DEPTH)) begin : g_cfg_error
        $error("flt_aclken_stream_ctrl: BUF_DEPTH must be at least LATENCY+1");
    end

    logic               run;
    logic               en;
    logic [LATENCY-1:0] vld;
    logic [OCC_W-1:0]   occ;
    logic               wr;
    logic               rd;

    // Hold the pipeline frozen for the first cycle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Credits gate the pipeline: never launch a token the FIFO could not absorb.
    assign en      = run & (occ < OCC_MAX);
    assign aclken  = en;
    assign s_ready = en;

    // Valid chain mirrors the pipeline stages and moves only when they do.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (en) begin
            vld[0] <= s_valid;
            for (int i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    // Landing a word in the FIFO coincides with the edge that shifts it out of the delay line.
    assign wr = en & vld[LATENCY-1];
    assign rd = m_valid & m_ready;

    // Credit count: in-flight plus buffered; a FIFO write is a transfer, not a change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else begin
            occ <= occ + OCC_W'(en & s_valid) - OCC_W'(rd);
        end
    end

    assign occupancy = occ;

    flt_stream_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (wr),
        .push_data  (pipe_dout),
        .pop        (rd),
        .head_valid (m_valid),
        .head_data  (m_data)
    );

endmodule

// File: doc/flt_aclken_stream_ctrl.md
# flt_aclken_stream_ctrl

Valid/ready stream adapter for the clock-enable-driven reciprocal datapath. It owns the global enable (`aclken`) of the fixed-latency pipeline that ends in the distributed delay line. It tracks in-flight tokens with a valid shift chain and captures the pipeline output into a first-word-fall-through skid FIFO, so the datapath can run under downstream backpressure without dropping data. It sits between the upstream source and the pipeline input, and between the pipeline output (the delay-line `dout`) and the downstream consumer.

## Interface
Parameters:
- `LATENCY`, 16, number of enabled clocks from pipeline input to pipeline output (equals delay-line `FIXED_DEPTH`); range 1-1024
- `DATA_WIDTH`, 16, width of the pipeline output word; range 1-256
- `BUF_DEPTH`, 18, skid FIFO entries and credit limit; must be at least `LATENCY+1`; full throughput needs at least `LATENCY+2`

Ports:
- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `s_valid` in 1: upstream offers a token this cycle.
- `s_ready` out 1: token accepted when `s_valid & s_ready`.
- `aclken` out 1: enable to the pipeline and delay line (their `i_aclken`).
- `pipe_dout` in `DATA_WIDTH`: pipeline/delay-line output.
- `m_valid` out 1: FIFO head valid.
- `m_data` out `DATA_WIDTH`: FIFO head, combinational from storage.
- `m_ready` in 1: head popped when `m_valid & m_ready`.
- `occupancy` out clog2(`BUF_DEPTH`+1): tokens in flight plus tokens buffered (debug/status).

## Operation
- `en = run & (occ < BUF_DEPTH)`, where `run` is a flag that becomes 1 on the first clock after `rst_n` deasserts.
- `aclken = en`, `s_ready = en`. There is no combinational path from `m_ready` to `s_ready`.
- Valid chain `vld[LATENCY-1:0]`, updated only when `en`: `vld[0] <= s_valid`, `vld[i] <= vld[i-1]`. Bubbles (`s_valid=0`) travel as zeros.
- FIFO write: `wr = en & vld[LATENCY-1]`. It captures `pipe_dout` on that edge, which is the same edge that shifts the word out of the delay line.
- FIFO pop: `rd = m_valid & m_ready`. `m_valid = (fifo_cnt != 0)`.
- Occupancy: `occ <= occ + (en & s_valid) - rd`. A FIFO write moves a token from in-flight to buffered, so it does not change `occ`.
- Invariants:
  - `occ == popcount(vld) + fifo_cnt`
  - `occ <= BUF_DEPTH`
  - FIFO never overflows, because a write requires a matching in-flight credit.
- Pointers are `$clog2(BUF_DEPTH)` bits wide and wrap explicitly at `BUF_DEPTH-1 -> 0`, so non-power-of-two depths are legal.
- Simultaneous FIFO write and pop, including write to an empty FIFO and pop of a one-entry FIFO: both are performed; `fifo_cnt` is unchanged.
- When `en` is low, the pipeline holds its state and `vld` holds.
  - A token at `vld[LATENCY-1]` waits.
  - Its data stays stable on `pipe_dout` because the delay line is also frozen.

## Timing
- Reset values (while `rst_n` is low and in the first cycle after):
  - `run=0`, so `aclken=0` and `s_ready=0`
  - `vld=0`, `occ=0`, pointers 0, `fifo_cnt=0`
  - `m_valid=0`, `occupancy=0`
  - `m_data` undefined, not reset
- `s_ready` rises in the second cycle after `rst_n` rises.
- Latency with no stall: token accepted at edge E, FIFO write at edge E+LATENCY, `m_valid` high in the cycle after edge E+LATENCY. Total LATENCY+1 cycles.
- Throughput:
  - 1 token/clk with `m_ready=1` and `BUF_DEPTH >= LATENCY+2`.
  - With `BUF_DEPTH = LATENCY+1`, a continuous stream alternates accept/stall.
- Backpressure: with `m_ready=0`, `s_ready` drops in the cycle after `occ` reaches `BUF_DEPTH`. The first pop re-enables on the following cycle.
- Reset asserted mid-stream: all in-flight and buffered tokens are discarded; no `m_valid` pulse appears afterward.

## Structure
- Shared package `flt_stream_pkg`:
  - clog2-based width function
  - `LATENCY`/`BUF_DEPTH` legality check (elaboration error if `BUF_DEPTH < LATENCY+1`)
- Sub-module `flt_stream_fifo`: `BUF_DEPTH` x `DATA_WIDTH` storage, synchronous write, asynchronous read, wrap-aware pointers, `fifo_cnt`.
- Top level: `run` flag, valid chain, occupancy counter, enable logic.
- About 200-300 lines total.

## Test plan
All scenarios use `LATENCY=4`, `BUF_DEPTH=6`, and a model delay line.
- Reset: hold `rst_n=0` for 5 clocks with `s_valid=1` -> `aclken=0`, `s_ready=0`, `m_valid=0`, `occupancy=0`. `s_ready=1` in the 2nd cycle after release.
- Streaming: 20 tokens 0x0001..0x0014 back-to-back, `m_ready=1` -> first `m_valid` 5 cycles after first accept, 20 consecutive outputs in order, no stall.
- Bubbles: `s_valid` pattern 1,0,0,1,1 with `m_ready=1` -> exactly 3 outputs in order, gaps preserved, `occupancy` never above 5.
- Backpressure: `m_ready=0` while streaming -> `s_ready` low once `occupancy=6`, exactly 6 tokens held. Release `m_ready` -> all 6 drain in order, then streaming resumes with no loss or duplication.
- Boundary: `BUF_DEPTH=5` (`LATENCY+1`), continuous input and `m_ready=1` -> accept every other cycle, data intact. Simultaneous write and pop at `fifo_cnt=1` keeps `fifo_cnt=1`.
- Reset mid-operation: assert `rst_n` with 6 tokens outstanding -> all state cleared, no stale output after release.
